pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_ctrl_pkg.sv | 17 +
 rtl/pc_fetch_ctrl_if.sv | 21 ++
 rtl/fetch_skid_buf.sv | 41 ++++
 rtl/pc_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types and constants for the fetch controller
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH         = 2'd0,
        HOLD          = 2'd1,
        REDIRECT_PEND = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - instruction memory request/ack bus
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry word+pc holding buffer with load/clear
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] word_in,
    input  logic [31:0] pc_in,
    output logic [31:0] word_out,
    output logic [31:0] pc_out
);

    logic [31:0] word_q, word_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        word_d = word_q;
        pc_d   = pc_q;
        if (load) begin
            word_d = word_in;
            pc_d   = pc_in;
        end else if (clear) begin
            word_d = '0;
            pc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            pc_q   <= '0;
        end else begin
            word_q <= word_d;
            pc_q   <= pc_d;
        end
    end

    assign word_out = word_q;
    assign pc_out   = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC sequencing, fetch handshake, stall skid and EX redirect
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pc_fetch_ctrl_if.master          imem,
    input  logic                     branch_taken_ex,
    input  logic [31:0]              pc_target_ex,
    input  logic                     stall_lu,
    output logic                     pc_valid,
    output logic [31:0]              instr_if,
    output logic [31:0]              pc_if,
    output logic                     flush_ifid,
    output logic                     flush_idex,
    output logic                     misalign_err,
    output logic [15:0]              redirect_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         misalign_q, misalign_d;

    logic         skid_load, skid_clear, valid_c, redirect_ok;
    logic [31:0]  skid_word, skid_pc, aligned_tgt;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .clear    (skid_clear),
        .word_in  (imem.imem_rdata),
        .pc_in    (pc_q),
        .word_out (skid_word),
        .pc_out   (skid_pc)
    );

    assign aligned_tgt = align_word(pc_target_ex);
    // A redirect arriving while one is already pending only flushes; the first target wins.
    assign redirect_ok = branch_taken_ex && (state_q != REDIRECT_PEND);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        valid_c    = 1'b0;
        case (state_q)
            FETCH: begin
                if (branch_taken_ex) begin
                    if (imem.imem_ack) begin
                        pc_d = aligned_tgt;
                    end else begin
                        target_d = aligned_tgt;
                        state_d  = REDIRECT_PEND;
                    end
                end else if (imem.imem_ack) begin
                    pc_d = pc_q + 32'd4;
                    if (stall_lu) begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        valid_c = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (branch_taken_ex) begin
                    skid_clear = 1'b1;
                    pc_d       = aligned_tgt;
                    state_d    = FETCH;
                end else if (!stall_lu) begin
                    valid_c    = 1'b1;
                    skid_clear = 1'b1;
                    state_d    = FETCH;
                end
            end
            REDIRECT_PEND: begin
                // The in-flight request must complete at the old address before retargeting.
                if (imem.imem_ack) begin
                    pc_d    = target_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        if (redirect_ok) begin
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
            misalign_d = |pc_target_ex[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            target_q   <= '0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem.imem_req  = rst_n && (state_q != HOLD);
    assign imem.imem_addr = pc_q;
    assign pc_valid       = rst_n && valid_c;
    assign flush_ifid     = rst_n && branch_taken_ex;
    assign flush_idex     = rst_n && branch_taken_ex;
    assign misalign_err   = misalign_q;
    assign redirect_cnt   = cnt_q;

    always_comb begin
        instr_if = '0;
        pc_if    = '0;
        if (rst_n) begin
            if (!valid_c) begin
                instr_if = NOP_INSTR;
            end else if (state_q == HOLD) begin
                instr_if = skid_word;
                pc_if    = skid_pc;
            end else begin
                instr_if = imem.imem_rdata;
                pc_if    = pc_q;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl with a queue-based reference model
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_taken_ex;
    logic [31:0] pc_target_ex;
    logic        stall_lu;
    logic        pc_valid;
    logic [31:0] instr_if;
    logic [31:0] pc_if;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misalign_err;
    logic [15:0] redirect_cnt;

    pc_fetch_ctrl_if imem_bus ();

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem            (imem_bus.master),
        .branch_taken_ex (branch_taken_ex),
        .pc_target_ex    (pc_target_ex),
        .stall_lu        (stall_lu),
        .pc_valid        (pc_valid),
        .instr_if        (instr_if),
        .pc_if           (pc_if),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .misalign_err    (misalign_err),
        .redirect_cnt    (redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        in_rst;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pcif;
        logic        flush;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: the buffered instruction and the pending target are each a 0/1-entry queue.
    logic [63:0] m_buf[$];
    logic [31:0] m_pend[$];
    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    logic        m_mis;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, e.req});
            chk("imem_addr", imem_bus.imem_addr, e.addr);
            chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.valid});
            chk("flush_ifid", {31'd0, flush_ifid}, {31'd0, e.flush});
            chk("flush_idex", {31'd0, flush_idex}, {31'd0, e.flush});
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
            chk("redirect_cnt", {16'd0, redirect_cnt}, {16'd0, e.cnt});
            if (e.valid || e.in_rst) begin
                chk("instr_if", instr_if, e.instr);
                chk("pc_if", pc_if, e.pcif);
            end
        end
    end

    task automatic step(input bit r, input bit br, input logic [31:0] tgt,
                        input bit st, input bit ak);
        exp_t        e;
        logic [31:0] al;
        bit          in_hold, pend, accepted;
        @(posedge clk);
        #1;
        rst_n                = r;
        branch_taken_ex      = br;
        pc_target_ex         = tgt;
        stall_lu             = st;
        imem_bus.imem_ack    = ak;
        imem_bus.imem_rdata  = ak ? mem_word(m_pc) : $urandom;
        al = {tgt[31:2], 2'b00};
        e.in_rst = !r;
        e.addr   = m_pc;
        e.mis    = m_mis;
        e.cnt    = m_cnt;
        if (!r) begin
            e.req = 0; e.valid = 0; e.instr = 0; e.pcif = 0; e.flush = 0;
            sb.push_back(e);
            m_pc = 32'h0; m_buf.delete(); m_pend.delete(); m_cnt = 0; m_mis = 0;
            return;
        end
        in_hold  = (m_buf.size() > 0);
        pend     = (m_pend.size() > 0);
        accepted = br && !pend;
        e.req    = !in_hold;
        e.flush  = br;
        e.valid  = 0;
        e.instr  = 0;
        e.pcif   = 0;
        if (in_hold) begin
            e.valid = !br && !st;
            e.instr = m_buf[0][63:32];
            e.pcif  = m_buf[0][31:0];
        end else if (!pend) begin
            e.valid = ak && !br && !st;
            e.instr = mem_word(m_pc);
            e.pcif  = m_pc;
        end
        sb.push_back(e);
        m_mis = accepted && (tgt[1:0] != 2'b00);
        if (accepted && m_cnt != 16'hFFFF) m_cnt++;
        if (pend) begin
            if (ak) m_pc = m_pend.pop_front();
        end else if (in_hold) begin
            if (br) begin
                m_buf.delete();
                m_pc = al;
            end else if (!st) begin
                m_buf.delete();
            end
        end else if (br) begin
            if (ak) m_pc = al;
            else m_pend.push_back(al);
        end else if (ak) begin
            if (st) m_buf.push_back({mem_word(m_pc), m_pc});
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        rst_n = 0; branch_taken_ex = 0; pc_target_ex = 0; stall_lu = 0;
        imem_bus.imem_ack = 0; imem_bus.imem_rdata = 0;
        m_pc = 0; m_cnt = 0; m_mis = 0;
        repeat (2) @(posedge clk);

        // sequential fetch from reset
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
        // stall at 0x10 into the skid buffer
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        // redirect while request outstanding, ack two cycles later
        step(1, 1, 32'h200, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // misaligned redirect with coincident ack
        step(1, 1, 32'h102, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // branch and stall together in HOLD
        step(1, 0, 0, 1, 1);
        step(1, 1, 32'h340, 1, 0);
        step(1, 0, 0, 0, 1);
        // pc wrap-around
        step(1, 1, 32'hFFFF_FFFC, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // reset in the middle of REDIRECT_PEND, with a late ack during reset
        step(1, 1, 32'h800, 0, 0);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 5) == 0),
                 $urandom,
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0));
        end

        // saturate the redirect counter
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) step(1, 1, $urandom, 0, 1);
        step(1, 0, 0, 0, 1);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
